// File: rtl/noc_to_txr_vc.sv
// Generic show-ahead FIFO: rd_data shows the oldest entry; count is registered.
// Caller must not write when full or read when empty.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
endmodule

// NoC egress to Avalon-ST: per-VC FIFOs, packet-granular round-robin, 2-cycle min latency.
// Per-VC ready is registered-count based (never combinational from o_ready); output holds until accepted.
module noc_to_txr_vc #(
  parameter int DATA_WIDTH = 512,
  parameter int NOC_WIDTH  = 600,
  parameter int NUM_VC     = 2,
  parameter int DEPTH      = 16,
  localparam int EMPTY_W   = $clog2(DATA_WIDTH/8),
  localparam int VC_W      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NOC_WIDTH-1:0]  i_data_in,
  input  logic                  i_valid_in,
  output logic [NUM_VC-1:0]     i_ready_out,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic                  o_sop,
  output logic                  o_eop,
  output logic [EMPTY_W-1:0]    o_empty,
  output logic                  o_drop,
  output logic [31:0]           o_pkt_count
);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic                  head;
    logic                  tail;
    logic [EMPTY_W-1:0]    empty;
    logic [DATA_WIDTH-1:0] data;
  } flit_t;
  localparam int FW = $bits(flit_t);

  typedef enum logic {IDLE, LOCKED} state_t;

  function automatic logic [VC_W-1:0] vc_add(input logic [VC_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_VC) s = s - NUM_VC;
    return VC_W'(s);
  endfunction

  flit_t           in_flit;
  logic [VC_W-1:0] in_vc;
  logic            unused_in;

  assign in_flit.head  = i_data_in[NOC_WIDTH-1];
  assign in_flit.tail  = i_data_in[NOC_WIDTH-2];
  assign in_flit.empty = i_data_in[DATA_WIDTH +: EMPTY_W];
  assign in_flit.data  = i_data_in[DATA_WIDTH-1:0];
  assign in_vc         = i_data_in[NOC_WIDTH-3 -: VC_W];
  assign unused_in     = ^i_data_in;

  logic [FW-1:0]     head_raw [NUM_VC];
  logic [CW-1:0]     fifo_count [NUM_VC];
  logic [NUM_VC-1:0] push;
  logic [NUM_VC-1:0] pop;
  logic [NUM_VC-1:0] nonempty;

  // A vc id outside 0..NUM_VC-1 matches no lane and is silently ignored.
  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign nonempty[v]    = (fifo_count[v] != '0);
    assign i_ready_out[v] = !reset && (fifo_count[v] != CW'(DEPTH));
    assign push[v]        = i_valid_in && i_ready_out[v] && (in_vc == VC_W'(v));

    fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (push[v]),
      .wr_data (in_flit),
      .rd_en   (pop[v]),
      .rd_data (head_raw[v]),
      .count   (fifo_count[v])
    );
  end

  state_t          state, state_nxt;
  logic [VC_W-1:0] cur_vc, cur_nxt;
  logic [VC_W-1:0] rr_ptr, rr_nxt;
  logic            sop_pend, sop_nxt;
  logic [31:0]     pkt_count, cnt_nxt;

  logic            found;
  logic [VC_W-1:0] sel;
  logic            valid;
  logic            drop;
  flit_t           sel_flit;
  flit_t           cur_flit;

  assign sel_flit = flit_t'(head_raw[sel]);
  assign cur_flit = flit_t'(head_raw[cur_vc]);

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (!found && nonempty[vc_add(rr_ptr, i)]) begin
        found = 1'b1;
        sel   = vc_add(rr_ptr, i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur_vc    <= '0;
      rr_ptr    <= '0;
      sop_pend  <= 1'b0;
      pkt_count <= '0;
    end else begin
      state     <= state_nxt;
      cur_vc    <= cur_nxt;
      rr_ptr    <= rr_nxt;
      sop_pend  <= sop_nxt;
      pkt_count <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur_vc;
    rr_nxt    = rr_ptr;
    sop_nxt   = sop_pend;
    cnt_nxt   = pkt_count;
    pop       = '0;
    drop      = 1'b0;
    valid     = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          if (sel_flit.head) begin
            cur_nxt   = sel;
            sop_nxt   = 1'b1;
            state_nxt = LOCKED;
          end else begin
            // Headless flit with no open packet: discard it and move past this VC.
            pop[sel] = 1'b1;
            drop     = 1'b1;
            rr_nxt   = vc_add(sel, 1);
          end
        end
      end
      LOCKED: begin
        valid = nonempty[cur_vc];
        if (valid && o_ready) begin
          pop[cur_vc] = 1'b1;
          sop_nxt     = 1'b0;
          if (cur_flit.tail) begin
            cnt_nxt   = pkt_count + 32'd1;
            rr_nxt    = vc_add(cur_vc, 1);
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_valid     = valid && !reset;
  assign o_drop      = drop && !reset;
  assign o_data      = cur_flit.data;
  assign o_empty     = cur_flit.empty;
  assign o_eop       = cur_flit.tail;
  assign o_sop       = sop_pend;
  assign o_pkt_count = pkt_count;
endmodule

// File: tb/tb_noc_to_txr_vc.sv
// Directed bench for noc_to_txr_vc: reset, latency, round-robin, full/backpressure, orphans, mid-packet reset.
module tb_noc_to_txr_vc;
  localparam int DW = 512;
  localparam int NW = 600;
  localparam int NV = 2;
  localparam int DP = 16;
  localparam int EW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NW-1:0] i_data_in;
  logic          i_valid_in;
  logic [NV-1:0] i_ready_out;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_ready;
  logic          o_sop;
  logic          o_eop;
  logic [EW-1:0] o_empty;
  logic          o_drop;
  logic [31:0]   o_pkt_count;

  noc_to_txr_vc #(.DATA_WIDTH(DW), .NOC_WIDTH(NW), .NUM_VC(NV), .DEPTH(DP)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_data_in   (i_data_in),
    .i_valid_in  (i_valid_in),
    .i_ready_out (i_ready_out),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_ready     (o_ready),
    .o_sop       (o_sop),
    .o_eop       (o_eop),
    .o_empty     (o_empty),
    .o_drop      (o_drop),
    .o_pkt_count (o_pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    int            stamp;
  } beat_t;

  beat_t got_q[$];
  beat_t exp_q[$];
  int cyc = 0;
  int drops = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (o_valid && o_ready) begin
        beat_t b;
        b.data  = o_data;
        b.sop   = o_sop;
        b.eop   = o_eop;
        b.empty = o_empty;
        b.stamp = cyc;
        got_q.push_back(b);
      end
      if (o_drop) drops++;
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int id);
    return {16{32'hA500_0000 | 32'(id)}};
  endfunction

  function automatic logic [NW-1:0] mk(input bit h, input bit t, input bit vc, input int id,
                                       input logic [EW-1:0] emp);
    logic [NW-1:0] f;
    f = '0;
    f[DW-1:0]      = pat(id);
    f[DW +: EW]    = emp;
    f[NW-1]        = h;
    f[NW-2]        = t;
    f[NW-3]        = vc;
    return f;
  endfunction

  task automatic expb(input int id, input bit sop, input bit eop, input logic [EW-1:0] emp);
    beat_t b;
    b.data  = pat(id);
    b.sop   = sop;
    b.eop   = eop;
    b.empty = emp;
    b.stamp = 0;
    exp_q.push_back(b);
  endtask

  // Call aligned just after a rising edge; returns with the flit accepted, one edge later.
  task automatic push(input logic [NW-1:0] f, output int stamp);
    int n = 0;
    i_data_in  = f;
    i_valid_in = 1'b1;
    @(negedge clk);
    while (!i_ready_out[f[NW-3]] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("push_timeout", n, 0);
    stamp = cyc;
    @(posedge clk);
    #1;
    i_valid_in = 1'b0;
  endtask

  task automatic set_rdy(input bit r);
    @(posedge clk);
    #1;
    o_ready = r;
  endtask

  task automatic wait_out(input string tag);
    int k = 0;
    while (got_q.size() < exp_q.size() && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    check({tag, ".beats"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s.data%0d", tag, i), got_q[i].data, exp_q[i].data);
      check($sformatf("%s.sop%0d", tag, i), got_q[i].sop, exp_q[i].sop);
      check($sformatf("%s.eop%0d", tag, i), got_q[i].eop, exp_q[i].eop);
      if (exp_q[i].eop) check($sformatf("%s.empty%0d", tag, i), got_q[i].empty, exp_q[i].empty);
    end
  endtask

  task automatic clear_q();
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0, s, d0;
    i_data_in  = '0;
    i_valid_in = 1'b0;
    o_ready    = 1'b0;
    reset      = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.valid", o_valid, 0);
    check("rst.ready", i_ready_out, 2'b00);
    check("rst.cnt", o_pkt_count, 0);
    check("rst.drop", o_drop, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post.valid", o_valid, 0);
    check("post.ready", i_ready_out, 2'b11);
    check("post.cnt", o_pkt_count, 0);
    check("post.drop", o_drop, 0);

    // Single 3-flit packet on VC0.
    set_rdy(1);
    push(mk(1, 0, 0, 1, 0), c0);
    push(mk(0, 0, 0, 2, 0), s);
    push(mk(0, 1, 0, 3, 5), s);
    expb(1, 1, 0, 0);
    expb(2, 0, 0, 0);
    expb(3, 0, 1, 5);
    wait_out("t1");
    if (got_q.size() >= 3) begin
      check("t1.latency", got_q[0].stamp - c0, 2);
      check("t1.beat2_cycle", got_q[2].stamp - c0, 4);
    end
    check("t1.pkt_count", o_pkt_count, 1);
    clear_q();

    // Interleaved arrival of two 4-flit packets.
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      push(mk(i == 0, i == 3, 0, 10 + i, 7), s);
      push(mk(i == 0, i == 3, 1, 20 + i, 3), s);
    end
    for (int i = 0; i < 4; i++) expb(10 + i, i == 0, i == 3, 7);
    for (int i = 0; i < 4; i++) expb(20 + i, i == 0, i == 3, 3);
    wait_out("t2");
    if (got_q.size() >= 5) check("t2.bubble", got_q[4].stamp - got_q[3].stamp, 2);
    check("t2.pkt_count", o_pkt_count, 3);
    clear_q();

    // Single-flit packets; VC0/VC1 tie after a VC1 packet must go to VC0.
    set_rdy(0);
    push(mk(1, 1, 1, 30, 1), s);
    push(mk(1, 1, 0, 31, 2), s);
    push(mk(1, 1, 1, 32, 4), s);
    set_rdy(1);
    expb(30, 1, 1, 1);
    expb(31, 1, 1, 2);
    expb(32, 1, 1, 4);
    wait_out("t3");
    check("t3.pkt_count", o_pkt_count, 6);
    clear_q();

    // Fill VC1 to DEPTH with output stalled.
    set_rdy(0);
    for (int i = 0; i < 15; i++) push(mk(i == 0, 0, 1, 40 + i, 0), s);
    @(negedge clk);
    check("t4.ready_at15", i_ready_out, 2'b11);
    @(posedge clk);
    #1;
    push(mk(0, 1, 1, 55, 9), s);
    @(negedge clk);
    check("t4.ready_full", i_ready_out, 2'b01);
    @(posedge clk);
    #1;
    i_data_in  = mk(0, 0, 1, 99, 0);
    i_valid_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 i_valid_in = 1'b0;
    @(negedge clk);
    check("t4.ready_still_full", i_ready_out, 2'b01);
    @(posedge clk);
    #1 o_ready = 1'b1;
    @(negedge clk);
    check("t4.ready_not_comb", i_ready_out, 2'b01);
    @(negedge clk);
    check("t4.ready_back", i_ready_out, 2'b11);
    for (int i = 0; i < 15; i++) expb(40 + i, i == 0, 0, 0);
    expb(55, 0, 1, 9);
    wait_out("t4");
    check("t4.pkt_count", o_pkt_count, 7);
    clear_q();

    // Orphan tail flit while idle, then a normal packet.
    d0 = drops;
    @(posedge clk);
    #1;
    push(mk(0, 1, 0, 60, 0), s);
    repeat (4) @(negedge clk);
    check("t5.drop_pulses", drops - d0, 1);
    check("t5.no_output", got_q.size(), 0);
    @(posedge clk);
    #1;
    push(mk(1, 0, 0, 61, 0), s);
    push(mk(0, 1, 0, 62, 11), s);
    expb(61, 1, 0, 0);
    expb(62, 0, 1, 11);
    wait_out("t5");
    check("t5.pkt_count", o_pkt_count, 8);
    clear_q();

    // Reset after two of four flits leave.
    set_rdy(0);
    for (int i = 0; i < 4; i++) push(mk(i == 0, i == 3, 0, 70 + i, 1), s);
    @(posedge clk);
    #1 o_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 o_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("t6.partial_beats", got_q.size(), 2);
    check("t6.rst_valid", o_valid, 0);
    check("t6.rst_ready", i_ready_out, 2'b00);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("t6.post_valid", o_valid, 0);
    check("t6.post_cnt", o_pkt_count, 0);
    check("t6.post_ready", i_ready_out, 2'b11);
    clear_q();
    d0 = drops;
    set_rdy(1);
    push(mk(1, 0, 1, 80, 0), s);
    push(mk(0, 1, 1, 81, 13), s);
    expb(80, 1, 0, 0);
    expb(81, 0, 1, 13);
    wait_out("t6");
    check("t6.pkt_count", o_pkt_count, 1);
    check("t6.no_drop", drops - d0, 0);
    clear_q();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
